// File: rtl/video_dram_sched.sv
// video_dram_sched: 4-clk DRAM slot arbiter (VID > TS > CPU/DMA round-robin > IDLE).
// Define VIDEO_SCHED_STARVE_EN to add the CPU starvation counter and forced CPU slots.
module video_dram_sched #(
  parameter int STARVE_LIM = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c3,
  input  logic       video_go,
  input  logic       v_ts,
  input  logic       tv_blank,
  input  logic       ts_req,
  input  logic       cpu_req,
  input  logic       dma_req,
  output logic       video_pre_next,
  output logic       ts_ack,
  output logic       cpu_ack,
  output logic       dma_ack,
  output logic [2:0] slot_own,
  output logic       cpu_starved
);
  localparam logic [2:0] IDLE = 3'd0, VID = 3'd1, TS = 3'd2, CPU = 3'd3, DMA = 3'd4;
  logic       rr_dma;
  logic       force_cpu;
  logic [2:0] nxt;
  if (STARVE_LIM < 2 || STARVE_LIM > 15) begin : g_lim_chk
    $error("STARVE_LIM must be within 2..15");
  end
`ifdef VIDEO_SCHED_STARVE_EN
  logic [3:0] starve_cnt;
  assign force_cpu = cpu_req && starve_cnt >= 4'(STARVE_LIM - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_cnt  <= '0;
      cpu_starved <= 1'b0;
    end else if (c3) begin
      starve_cnt  <= (!cpu_req || nxt == CPU) ? 4'd0 : (&starve_cnt) ? starve_cnt : starve_cnt + 4'd1;
      cpu_starved <= force_cpu;
    end
`else
  assign force_cpu   = 1'b0;
  assign cpu_starved = 1'b0;
`endif
  // rr_dma set means the last pair winner was CPU, so DMA is favoured next
  always_comb
    nxt = force_cpu                    ? CPU :
          video_go                     ? VID :
          (ts_req && (v_ts || tv_blank)) ? TS  :
          (cpu_req && dma_req)         ? (rr_dma ? DMA : CPU) :
          cpu_req                      ? CPU :
          dma_req                      ? DMA : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_own       <= IDLE;
      rr_dma         <= 1'b0;
      video_pre_next <= 1'b0;
      ts_ack         <= 1'b0;
      cpu_ack        <= 1'b0;
      dma_ack        <= 1'b0;
    end else begin
      video_pre_next <= c3 && nxt == VID;
      ts_ack         <= c3 && nxt == TS;
      cpu_ack        <= c3 && nxt == CPU;
      dma_ack        <= c3 && nxt == DMA;
      if (c3) slot_own <= nxt;
      if (c3 && (nxt == CPU || nxt == DMA)) rr_dma <= nxt == CPU;
    end
endmodule

// File: tb/tb_video_dram_sched.sv
// tb_video_dram_sched: scoreboard bench with a slot-level reference model of the DRAM arbiter.
module tb_video_dram_sched;
  localparam int LIM = 8;
`ifdef VIDEO_SCHED_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  logic clk = 0, rst_n = 0, c3 = 0, video_go = 0, v_ts = 0, tv_blank = 0;
  logic ts_req = 0, cpu_req = 0, dma_req = 0;
  logic video_pre_next, ts_ack, cpu_ack, dma_ack, cpu_starved;
  logic [2:0] slot_own;
  int checks = 0, errors = 0, ph = 0;
  typedef struct packed {logic [2:0] own; logic starved;} exp_t;
  exp_t exp_q[$], glog[$];
  bit dec_flag = 0;

  always #5 clk = ~clk;

  video_dram_sched #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .c3(c3), .video_go(video_go), .v_ts(v_ts), .tv_blank(tv_blank),
    .ts_req(ts_req), .cpu_req(cpu_req), .dma_req(dma_req), .video_pre_next(video_pre_next),
    .ts_ack(ts_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack), .slot_own(slot_own),
    .cpu_starved(cpu_starved)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one decision per slot, lost-slot count kept as a plain integer
  initial begin : model
    int   lost;
    bit   cpu_last;
    exp_t e;
    lost = 0;
    cpu_last = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        lost = 0;
        cpu_last = 0;
        dec_flag = 0;
      end else begin
        dec_flag = c3;
        if (c3) begin
          e.starved = STARVE && cpu_req && lost >= LIM - 1;
          if (e.starved) e.own = 3;
          else if (video_go) e.own = 1;
          else if (ts_req && (v_ts || tv_blank)) e.own = 2;
          else if (cpu_req && (!dma_req || !cpu_last)) e.own = 3;
          else if (dma_req) e.own = 4;
          else e.own = 0;
          if (e.own == 3) cpu_last = 1;
          else if (e.own == 4) cpu_last = 0;
          lost = (!cpu_req || e.own == 3) ? 0 : (lost < 15 ? lost + 1 : 15);
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e, cur;
    logic [3:0] pul, want;
    cur = '0;
    forever begin
      @(negedge clk);
      pul = {video_pre_next, ts_ack, cpu_ack, dma_ack};
      if (!rst_n) begin
        cur = '0;
        chk("reset_outputs", 32'({pul, slot_own, cpu_starved}), 0);
      end else if (dec_flag) begin
        if (exp_q.size() == 0) chk("queue_underflow", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          cur = e;
          glog.push_back(e);
          want = e.own == 1 ? 4'b1000 : e.own == 2 ? 4'b0100 : e.own == 3 ? 4'b0010 :
                 e.own == 4 ? 4'b0001 : 4'b0000;
          chk("grant_pulse", 32'(pul), 32'(want));
          chk("slot_own", 32'(slot_own), 32'(e.own));
          chk("cpu_starved", 32'(cpu_starved), 32'(e.starved));
        end
      end else begin
        chk("pulse_outside_slot_start", 32'(pul), 0);
        chk("slot_hold", 32'({slot_own, cpu_starved}), 32'(cur));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    ph = (ph + 1) % 4;
    c3 = (ph == 3);
  endtask

  task automatic align();
    do tick(); while (!c3);
  endtask

  task automatic slots(input int n);
    repeat (4 * n) tick();
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk("async_reset", 32'({video_pre_next, ts_ack, cpu_ack, dma_ack, slot_own, cpu_starved}), 0);
    repeat (2) tick();
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  function automatic int own_at(input int i);
    return i < glog.size() ? int'(glog[i].own) : 7;
  endfunction

  function automatic int cnt_own(input int o);
    int n = 0;
    foreach (glog[i]) if (int'(glog[i].own) == o) n++;
    return n;
  endfunction

  initial begin : stim
    int vids;
    rst_pulse();
    // Reset in the middle of a video slot, then the first decision after release
    align();
    video_go = 1;
    repeat (2) tick();
    rst_pulse();
    align();
    glog.delete();
    slots(1);
    chk("first_grant_after_reset", own_at(0), 1);
    // Ten video slots, no CPU traffic
    align();
    glog.delete();
    slots(10);
    video_go = 0;
    slots(1);
    chk("vid_10_slots", cnt_own(1), 10);
    chk("vid_no_acks", cnt_own(2) + cnt_own(3) + cnt_own(4), 0);
    // CPU/DMA fairness starting from the reset pointer
    glog.delete();
    cpu_req = 1;
    dma_req = 1;
    slots(4);
    cpu_req = 0;
    dma_req = 0;
    slots(1);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), own_at(i), (i % 2) ? 4 : 3);
    // TS gated off outside its windows, then admitted during blanking
    glog.delete();
    ts_req = 1;
    cpu_req = 1;
    slots(1);
    tv_blank = 1;
    slots(1);
    ts_req = 0;
    cpu_req = 0;
    tv_blank = 0;
    slots(1);
    chk("ts_gated_cpu_wins", own_at(0), 3);
    chk("ts_in_blank", own_at(1), 2);
    // Short CPU pulse between decisions, then continuous starvation under video
    rst_pulse();
    align();
    glog.delete();
    video_go = 1;
    tick();
    cpu_req = 1;
    repeat (2) tick();
    cpu_req = 0;
    tick();
    slots(1);
    chk("dropped_req_no_cpu", cnt_own(3), 0);
    glog.delete();
    cpu_req = 1;
    slots(8);
    video_go = 0;
    cpu_req = 0;
    slots(1);
    vids = 0;
    for (int i = 0; i < 7; i++) if (own_at(i) == 1) vids++;
    chk("starve_vid_slots", vids, 7);
    chk("starve_slot8_own", own_at(7), STARVE ? 3 : 1);
    chk("starve_slot8_flag", glog.size() > 7 ? 32'(glog[7].starved) : 32'hff, 32'(STARVE));
    // Randomized traffic with sticky video windows and occasional resets
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 15) == 0) video_go = ~video_go;
      v_ts = $urandom_range(0, 3) == 0;
      tv_blank = $urandom_range(0, 3) == 0;
      ts_req = $urandom_range(0, 9) < 5;
      cpu_req = $urandom_range(0, 9) < 7;
      dma_req = $urandom_range(0, 9) < 5;
      if ($urandom_range(0, 799) == 0) rst_pulse();
    end
    {video_go, v_ts, tv_blank, ts_req, cpu_req, dma_req} = '0;
    slots(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
